// File: rtl/montacargas_pkg.sv
// Shared motor command encoding and plant states for the elevator emulator.
package montacargas_pkg;

  localparam logic [1:0] MOTOR_PARAR  = 2'b00;
  localparam logic [1:0] MOTOR_BAJAR  = 2'b01;
  localparam logic [1:0] MOTOR_SUBIR  = 2'b10;
  localparam logic [1:0] MOTOR_ILEGAL = 2'b11;

  typedef enum logic [2:0] {
    REPOSO,
    SUBIENDO,
    BAJANDO,
    INERCIA,
    FALLA
  } estado_t;

endpackage

// File: rtl/generador_de_pasos.sv
// Step timer: pulses once every TICKS_POR_PASO enabled cycles.
module generador_de_pasos #(
  parameter int TICKS_POR_PASO = 40000
) (
  input  logic clockBase_4MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic paso
);

  localparam int W = (TICKS_POR_PASO > 1) ? $clog2(TICKS_POR_PASO) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TICKS_POR_PASO - 1);

  logic [W-1:0] cuenta;

  // Not gated by clear: the FSM already ranks stop/reversal/fault above a step.
  assign paso = enable && (cuenta == ULTIMO);

  always_ff @(posedge clockBase_4MHz or negedge reset) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (clear || !enable) begin
      cuenta <= '0;
    end else if (cuenta == ULTIMO) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/emulador_montacargas.sv
// Three-floor elevator plant emulator; define EMULADOR_INERCIA_EN
// to let the car coast one extra step after a stop command.
import montacargas_pkg::*;

module emulador_montacargas #(
  parameter int TICKS_POR_PASO = 40000,
  parameter int POS_PISO2      = 100,
  parameter int POS_PISO3      = 200
) (
  input  logic       clockBase_4MHz,
  input  logic       reset,
  input  logic [1:0] driverMotor,
  input  logic       puertaAbierta,
  output logic       FC1,
  output logic       FC2,
  output logic       FC3,
  output logic       SPC,
  output logic [7:0] posicion,
  output logic       falla
);

  localparam logic [7:0] PISO2 = 8'(POS_PISO2);
  localparam logic [7:0] TOPE  = 8'(POS_PISO3);

  estado_t    estado, estadoSig;
  logic [7:0] posSig;
  logic       subirReg, subirSig;
  logic       puertaS1, puertaS2;
  logic       paso, limpiar, habil;
  logic       mover, dirSube, enLimite;
  logic [7:0] posPaso;

  generador_de_pasos #(
    .TICKS_POR_PASO(TICKS_POR_PASO)
  ) uPasos (
    .clockBase_4MHz(clockBase_4MHz),
    .reset         (reset),
    .clear         (limpiar),
    .enable        (habil),
    .paso          (paso)
  );

  assign mover = (driverMotor == MOTOR_SUBIR) ||
                 (driverMotor == MOTOR_BAJAR);
  assign habil = (estado == SUBIENDO) ||
                 (estado == BAJANDO) ||
                 (estado == INERCIA);
  assign limpiar = (estadoSig != estado) || !habil;

  assign dirSube = (estado == SUBIENDO) ||
                   ((estado == INERCIA) && subirReg);
  assign enLimite = dirSube ? (posicion == TOPE)
                            : (posicion == 8'd0);
  assign posPaso = dirSube ? posicion + 8'd1
                           : posicion - 8'd1;

  assign subirSig = (estado == SUBIENDO) ? 1'b1 :
                    (estado == BAJANDO)  ? 1'b0 : subirReg;

  assign falla = (estado == FALLA);
  assign SPC   = ~puertaS2;

  always_comb begin
    estadoSig = estado;
    posSig    = posicion;
    case (estado)
      REPOSO: begin
        if (driverMotor == MOTOR_ILEGAL) begin
          estadoSig = FALLA;
        end else if (mover && puertaS2) begin
          estadoSig = FALLA;
        end else if (driverMotor == MOTOR_SUBIR) begin
          estadoSig = SUBIENDO;
        end else if (driverMotor == MOTOR_BAJAR) begin
          estadoSig = BAJANDO;
        end
      end
      SUBIENDO, BAJANDO: begin
        if (driverMotor == MOTOR_ILEGAL) begin
          estadoSig = FALLA;
        end else if (mover && puertaS2) begin
          estadoSig = FALLA;
        end else if (driverMotor == MOTOR_PARAR) begin
`ifdef EMULADOR_INERCIA_EN
          estadoSig = INERCIA;
`else
          estadoSig = REPOSO;
`endif
        end else if ((driverMotor == MOTOR_SUBIR) != dirSube) begin
          estadoSig = dirSube ? BAJANDO : SUBIENDO;
        end else if (paso) begin
          if (enLimite) estadoSig = FALLA;
          else          posSig    = posPaso;
        end
      end
      INERCIA: begin
        if (driverMotor == MOTOR_ILEGAL) begin
          estadoSig = FALLA;
        end else if (paso) begin
          if (enLimite) begin
            estadoSig = FALLA;
          end else begin
            posSig    = posPaso;
            estadoSig = REPOSO;
          end
        end
      end
      FALLA:   estadoSig = FALLA;
      default: estadoSig = REPOSO;
    endcase
  end

  always_ff @(posedge clockBase_4MHz or negedge reset) begin
    if (!reset) begin
      estado   <= REPOSO;
      posicion <= 8'd0;
      subirReg <= 1'b0;
    end else begin
      estado   <= estadoSig;
      posicion <= posSig;
      subirReg <= subirSig;
    end
  end

  // Sensor outputs lag posicion by one cycle, like the real switches.
  always_ff @(posedge clockBase_4MHz or negedge reset) begin
    if (!reset) begin
      FC1      <= 1'b1;
      FC2      <= 1'b0;
      FC3      <= 1'b0;
      puertaS1 <= 1'b0;
      puertaS2 <= 1'b0;
    end else begin
      FC1      <= (posicion == 8'd0);
      FC2      <= (posicion == PISO2);
      FC3      <= (posicion == TOPE);
      puertaS1 <= puertaAbierta;
      puertaS2 <= puertaS1;
    end
  end

endmodule

// File: tb/tb_emulador_montacargas.sv
// Randomized bench for emulador_montacargas against a behavioural plant model.
module tb_emulador_montacargas;

  localparam int T  = 4;
  localparam int P2 = 10;
  localparam int P3 = 20;
`ifdef EMULADOR_INERCIA_EN
  localparam bit INER = 1'b1;
`else
  localparam bit INER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] driverMotor;
  logic       puertaAbierta;
  logic       FC1, FC2, FC3, SPC, falla;
  logic [7:0] posicion;

  int nChecks = 0;
  int nPass   = 0;

  // Model: position, direction (+1/-1/0), cycles into current step.
  int mPos, mDir, mElapsed, fcPos;
  bit mFault, mCoast, d1, d2;

  emulador_montacargas #(
    .TICKS_POR_PASO(T),
    .POS_PISO2     (P2),
    .POS_PISO3     (P3)
  ) dut (
    .clockBase_4MHz(clk),
    .reset         (reset),
    .driverMotor   (driverMotor),
    .puertaAbierta (puertaAbierta),
    .FC1           (FC1),
    .FC2           (FC2),
    .FC3           (FC3),
    .SPC           (SPC),
    .posicion      (posicion),
    .falla         (falla)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s at %0t: got %0h expected %0h",
                  tag, $time, obs, exp);
  endtask

  task automatic modelReset();
    mPos = 0; mDir = 0; mElapsed = 0; fcPos = 0;
    mFault = 0; mCoast = 0; d1 = 0; d2 = 0;
  endtask

  task automatic tryMove();
    int target;
    target = mPos + mDir;
    if (target < 0 || target > P3) mFault = 1;
    else mPos = target;
  endtask

  task automatic modelStep(input logic [1:0] c, input bit door);
    bit doorS;
    int want;
    doorS = d2;
    fcPos = mPos;
    if (mFault) begin
    end else if (c == 2'b11) begin
      mFault = 1;
    end else if (mCoast) begin
      if (mElapsed == T - 1) begin
        tryMove();
        mCoast = 0;
        mDir = 0;
        mElapsed = 0;
      end else mElapsed++;
    end else if (c != 2'b00 && doorS) begin
      mFault = 1;
    end else if (c == 2'b00) begin
      if (mDir != 0 && INER) mCoast = 1;
      else mDir = 0;
      mElapsed = 0;
    end else begin
      want = (c == 2'b10) ? 1 : -1;
      if (mDir != want) begin
        mDir = want;
        mElapsed = 0;
      end else if (mElapsed == T - 1) begin
        mElapsed = 0;
        tryMove();
      end else mElapsed++;
    end
    d2 = d1;
    d1 = door;
  endtask

  task automatic compare(input string tag);
    logic [4:0] expFlags;
    expFlags = {mFault, fcPos == 0, fcPos == P2, fcPos == P3, !d2};
    check({tag, ".pos"}, {24'd0, posicion}, mPos);
    check({tag, ".flags"}, {27'd0, falla, FC1, FC2, FC3, SPC},
          {27'd0, expFlags});
  endtask

  task automatic tick(input logic [1:0] c, input bit door);
    driverMotor = c;
    puertaAbierta = door;
    @(posedge clk);
    modelStep(c, door);
    @(negedge clk);
    compare("cyc");
  endtask

  task automatic hold(input logic [1:0] c, input bit door, input int n);
    for (int i = 0; i < n; i++) tick(c, door);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    #2 compare("rst");
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    driverMotor = 2'b00;
    puertaAbierta = 1'b0;
    modelReset();
    doReset();
    // Climb to floor 2 and stop.
    hold(2'b10, 0, 41);
    hold(2'b00, 0, 5);
    // Continue to the top and overtravel.
    hold(2'b10, 0, 60);
    hold(2'b00, 0, 4);
    doReset();
    // Illegal command mid-shaft.
    hold(2'b10, 0, 21);
    tick(2'b11, 0);
    hold(2'b00, 0, 3);
    doReset();
    // Door open, then a move command.
    hold(2'b00, 1, 3);
    hold(2'b01, 1, 3);
    doReset();
    // Stop right after reaching position 9.
    hold(2'b10, 0, 37);
    hold(2'b00, 0, 7);
    // Reversal late in a step.
    hold(2'b10, 0, 4);
    hold(2'b01, 0, 10);
    hold(2'b00, 0, 3);
    doReset();
    for (int s = 0; s < 300; s++) begin
      int r, len;
      logic [1:0] c;
      bit door;
      r = $urandom_range(0, 99);
      c = (r < 3) ? 2'b11 : (r < 45) ? 2'b10 : (r < 80) ? 2'b01 : 2'b00;
      door = ($urandom_range(0, 19) == 0);
      len = $urandom_range(1, 40);
      hold(c, door, len);
      if (mFault || $urandom_range(0, 29) == 0) doReset();
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
